// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
// Optional lap-hold feature is enabled with the LAP_HOLD_EN macro.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int         BCD_W        = 4;
  localparam logic [3:0] CS_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DEC_MAX      = 4'd9;

  // Two-digit BCD encoding of a small integer (0..99).
  function automatic logic [7:0] toBcd2(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control pulses, status flags and display digits of the stopwatch core.
// lap/hold exist only when LAP_HOLD_EN is defined.
interface stopwatch_core_if;
  import stopwatch_core_pkg::*;

  logic             tick_src;
  logic             start_stop;
  logic             clear;
`ifdef LAP_HOLD_EN
  logic             lap;
  logic             hold;
`endif
  logic             running;
  logic             ovf;
  logic [BCD_W-1:0] d_min1;
  logic [BCD_W-1:0] d_min0;
  logic [BCD_W-1:0] d_sec1;
  logic [BCD_W-1:0] d_sec0;
  logic [BCD_W-1:0] d_cs1;
  logic [BCD_W-1:0] d_cs0;

  modport master (
`ifdef LAP_HOLD_EN
    output lap,
    input  hold,
`endif
    output tick_src, start_stop, clear,
    input  running, ovf, d_min1, d_min0, d_sec1, d_sec0, d_cs1, d_cs0
  );

  modport slave (
`ifdef LAP_HOLD_EN
    input  lap,
    output hold,
`endif
    input  tick_src, start_stop, clear,
    output running, ovf, d_min1, d_min0, d_sec1, d_sec0, d_cs1, d_cs0
  );

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD counter digit: wraps at i_max and reports carry on that increment.
module bcd_digit
  import stopwatch_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic [BCD_W-1:0] i_max,
  output logic [BCD_W-1:0] o_q,
  output logic             o_carry
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= (r_q == i_max) ? '0 : r_q + 4'd1;
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_inc & (r_q == i_max);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: 100 Hz tick detect, start/pause/clear FSM, MM:SS.CC BCD count.
// Define LAP_HOLD_EN to add the lap-hold display freeze.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int MIN_LIMIT = 59,
  parameter bit WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  sw
);

  localparam logic [7:0] MIN_BCD = toBcd2(MIN_LIMIT);

  state_t r_state;
  state_t w_nextState;
  logic   r_tickQ;
  logic   r_running;
  logic   r_ovf;

  logic w_tick;
  logic w_countEn;
  logic w_full;
  logic w_fullHit;
  logic w_inc;
  logic w_digitClr;
  logic w_ovfNext;

  logic [BCD_W-1:0] w_cs0, w_cs1, w_sec0, w_sec1, w_min0, w_min1;
  logic             w_cCs0, w_cCs1, w_cSec0, w_cSec1, w_cMin0, w_unusedCarry;
  logic [23:0]      w_count;
  logic [23:0]      w_disp;

  assign w_tick    = sw.tick_src & ~r_tickQ;
  assign w_countEn = w_tick & (r_state == ST_RUN);
  assign w_full    = ({w_min1, w_min0} == MIN_BCD) && (w_sec1 == SEC_TENS_MAX) &&
                     (w_sec0 == DEC_MAX) && (w_cs1 == CS_MAX) && (w_cs0 == CS_MAX);
  assign w_fullHit = w_countEn & w_full;
  assign w_count   = {w_min1, w_min0, w_sec1, w_sec0, w_cs1, w_cs0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tickQ   <= 1'b0;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tickQ   <= sw.tick_src;
      r_running <= (w_nextState == ST_RUN);
      r_ovf     <= w_ovfNext;
    end
  end

  // A saturated count (ovf set) can only be left through clear.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (sw.start_stop) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (w_fullHit && !WRAP)  w_nextState = ST_PAUSE;
        else if (sw.start_stop)  w_nextState = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (sw.clear)                     w_nextState = ST_IDLE;
        else if (sw.start_stop && !r_ovf) w_nextState = ST_RUN;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Wrapping zeroes every digit through clr, which beats any pending increment.
  always_comb begin
    w_inc      = w_countEn & ~(w_full & ~WRAP);
    w_digitClr = ((r_state == ST_PAUSE) & sw.clear) | (w_fullHit & WRAP);
    w_ovfNext  = r_ovf;
    if (w_fullHit)                               w_ovfNext = 1'b1;
    else if (WRAP)                               w_ovfNext = 1'b0;
    else if ((r_state == ST_PAUSE) && sw.clear)  w_ovfNext = 1'b0;
  end

  bcd_digit uCs0 (.clk(clk), .rst_n(rst_n), .i_inc(w_inc), .i_clr(w_digitClr),
                  .i_max(CS_MAX), .o_q(w_cs0), .o_carry(w_cCs0));
  bcd_digit uCs1 (.clk(clk), .rst_n(rst_n), .i_inc(w_cCs0), .i_clr(w_digitClr),
                  .i_max(CS_MAX), .o_q(w_cs1), .o_carry(w_cCs1));
  bcd_digit uSec0 (.clk(clk), .rst_n(rst_n), .i_inc(w_cCs1), .i_clr(w_digitClr),
                   .i_max(DEC_MAX), .o_q(w_sec0), .o_carry(w_cSec0));
  bcd_digit uSec1 (.clk(clk), .rst_n(rst_n), .i_inc(w_cSec0), .i_clr(w_digitClr),
                   .i_max(SEC_TENS_MAX), .o_q(w_sec1), .o_carry(w_cSec1));
  bcd_digit uMin0 (.clk(clk), .rst_n(rst_n), .i_inc(w_cSec1), .i_clr(w_digitClr),
                   .i_max(DEC_MAX), .o_q(w_min0), .o_carry(w_cMin0));
  bcd_digit uMin1 (.clk(clk), .rst_n(rst_n), .i_inc(w_cMin0), .i_clr(w_digitClr),
                   .i_max(DEC_MAX), .o_q(w_min1), .o_carry(w_unusedCarry));

`ifdef LAP_HOLD_EN
  logic        r_hold;
  logic [23:0] r_snap;

  // The snapshot is the pre-edge count, i.e. exactly what was on display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 1'b0;
      r_snap <= '0;
    end else if (sw.clear) begin
      r_hold <= 1'b0;
    end else if (sw.lap && (r_state == ST_RUN)) begin
      r_hold <= ~r_hold;
      if (!r_hold) r_snap <= w_count;
    end
  end

  assign w_disp  = r_hold ? r_snap : w_count;
  assign sw.hold = r_hold;
`else
  assign w_disp = w_count;
`endif

  assign sw.running = r_running;
  assign sw.ovf     = r_ovf;
  assign sw.d_min1  = w_disp[23:20];
  assign sw.d_min0  = w_disp[19:16];
  assign sw.d_sec1  = w_disp[15:12];
  assign sw.d_sec0  = w_disp[11:8];
  assign sw.d_cs1   = w_disp[7:4];
  assign sw.d_cs0   = w_disp[3:0];

endmodule
